// File: rtl/gf12_sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gf12_sram_ctrl_pkg
//
// Shared definitions for the SRAM stream controller front end of the
// 20-address-bit, 64-bit byte-enable banked SRAM wrapper.
//
// Contents:
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_BANK_LSB : default geometry
//   bank_idx_t                                : bank select field type
//   arb_prio_e                                : round-robin owner of a bank conflict
//   bank_of()                                 : bank index of an address (default geometry)
// ---------------------------------------------------------------------------
package gf12_sram_ctrl_pkg;

    localparam int SRAM_ADDR_W   = 20;
    localparam int SRAM_DATA_W   = 64;
    localparam int SRAM_BANK_LSB = 13;

    typedef logic [SRAM_ADDR_W-SRAM_BANK_LSB-1:0] bank_idx_t;

    // Which channel wins the next same-bank conflict.
    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } arb_prio_e;

    function automatic bank_idx_t bank_of(input logic [SRAM_ADDR_W-1:0] addr);
        return addr[SRAM_ADDR_W-1:SRAM_BANK_LSB];
    endfunction

endpackage

// File: rtl/gf12_sram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// gf12_sram_rsp_fifo
//
// Small circular FIFO holding read responses that the consumer has not yet
// taken. Push and pop may happen in the same cycle (count unchanged, both
// pointers advance). Overflow and underflow are prevented by the caller,
// which only pushes when it holds a credit and only pops when non-empty.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail this cycle
//   push_data  : data to store
//   pop        : drop the head entry this cycle
//   head       : oldest stored entry (meaningless while count == 0)
//   count      : number of stored entries
// ---------------------------------------------------------------------------
module gf12_sram_rsp_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/gf12_sram64_be_stream_ctrl.sv
// ---------------------------------------------------------------------------
// gf12_sram64_be_stream_ctrl
//
// Request/response front end for the banked single-port SRAM wrapper
// gf12_sram64_be_20abits. Turns a valid/ready write channel and a
// valid/ready read-request channel into the wrapper's single-cycle
// write (CE0/A0/D0/WE0/WEM0) and read (CE1/A1) strobes, arbitrates
// same-bank conflicts round-robin, and buffers Q1 read data so that
// consumer backpressure never drops a response.
//
// Handshake rule (all three channels): a transfer happens on a rising CLK
// edge where valid and ready are both high. ready may depend
// combinationally on valid; valid must never depend on ready, and a
// producer holds valid and its payload until the transfer happens.
//
// Ports:
//   CLK, RST                        : clock, synchronous active-high reset
//   wr_valid/wr_ready               : write request handshake
//   wr_addr/wr_data/wr_mask         : write payload (mask is per bit)
//   rd_req_valid/rd_req_ready       : read request handshake
//   rd_addr                         : read address
//   rd_rsp_valid/rd_rsp_ready       : read response handshake
//   rd_rsp_data                     : read response data, in request order
//   CE0/A0/D0/WE0/WEM0              : SRAM write port, driven in accept cycle
//   CE1/A1                          : SRAM read port, driven in accept cycle
//   Q1                              : SRAM read data, one cycle after CE1
//   stat_conflicts                  : saturating count of bank-conflict cycles
//
// Build option:
//   SRAM_STREAM_CTRL_STATS_EN : when defined, stat_conflicts counts conflict
//                               cycles; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module gf12_sram64_be_stream_ctrl
    import gf12_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int BANK_LSB  = SRAM_BANK_LSB,
    parameter int RSP_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [DATA_W-1:0] rd_rsp_data,

    output logic              CE0,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    output logic              WE0,
    output logic [DATA_W-1:0] WEM0,

    output logic              CE1,
    output logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] Q1,

    output logic [31:0]       stat_conflicts
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    // ------------------------------------------------------------------
    // Response buffering state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              inflight;     // a read was issued last cycle; Q1 is live now

    // ------------------------------------------------------------------
    // Credit: every accepted, undelivered read owns one FIFO slot, whether
    // its data already sits in the FIFO or is still on Q1. This is what
    // makes an unconditional push of Q1 safe.
    // ------------------------------------------------------------------
    logic [CNT_W:0] used_slots;
    logic           have_credit;

    assign used_slots  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    assign have_credit = used_slots < (CNT_W + 1)'(RSP_DEPTH);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    arb_prio_e prio;
    arb_prio_e prio_next;
    logic      same_bank;
    logic      conflict;
    logic      wr_ok;
    logic      rd_ok;

    assign same_bank = (wr_addr[ADDR_W-1:BANK_LSB] == rd_addr[ADDR_W-1:BANK_LSB]);

    always_comb begin
        conflict  = 1'b0;
        wr_ok     = 1'b0;
        rd_ok     = 1'b0;
        prio_next = prio;

        // A read without credit cannot be issued, so it is not competing
        // for the bank: it neither blocks the write nor moves the pointer.
        conflict = wr_valid && rd_req_valid && same_bank && have_credit;

        if (!RST) begin
            rd_ok = rd_req_valid && have_credit && !(conflict && (prio == PRIO_WR));
            wr_ok = wr_valid && !(conflict && (prio == PRIO_RD));
        end

        // Hand priority to whichever side just lost.
        if (conflict) begin
            prio_next = (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prio <= PRIO_WR;
        end else begin
            prio <= prio_next;
        end
    end

    assign wr_ready     = wr_ok;
    assign rd_req_ready = rd_ok;

    // ------------------------------------------------------------------
    // SRAM strobes: issued in the accept cycle, zero otherwise so the
    // wrapper never sees stale addresses or data.
    // ------------------------------------------------------------------
    assign CE0  = wr_ok;
    assign WE0  = wr_ok;
    assign A0   = wr_ok ? wr_addr : '0;
    assign D0   = wr_ok ? wr_data : '0;
    assign WEM0 = wr_ok ? wr_mask : '0;

    assign CE1  = rd_ok;
    assign A1   = rd_ok ? rd_addr : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_ok;
        end
    end

    // ------------------------------------------------------------------
    // Response path. An empty FIFO lets Q1 bypass straight to the
    // consumer; otherwise the FIFO head goes out first and Q1 queues
    // behind it, which keeps responses in request order.
    // ------------------------------------------------------------------
    assign fifo_empty = (fifo_count == '0);
    assign fifo_pop   = !fifo_empty && rd_rsp_ready;
    assign fifo_push  = inflight && !(fifo_empty && rd_rsp_ready);

    assign rd_rsp_valid = !RST && (!fifo_empty || inflight);

    always_comb begin
        rd_rsp_data = '0;
        if (!RST) begin
            if (!fifo_empty) begin
                rd_rsp_data = fifo_head;
            end else if (inflight) begin
                rd_rsp_data = Q1;
            end
        end
    end

    gf12_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (DATA_W)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (fifo_push),
        .push_data (Q1),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Conflict statistics
    // ------------------------------------------------------------------
`ifdef SRAM_STREAM_CTRL_STATS_EN
    logic [31:0] conflict_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    assign stat_conflicts = conflict_cnt;
`else
    assign stat_conflicts = '0;
`endif

endmodule
